// File: rtl/layers_post_pkg.sv
// rtl/layers_post_pkg.sv - config map, field layout and config record for layers_post
package layers_post_pkg;

   // Config addresses decoded in the CNN datapath
   localparam int CFG_LAYERS = 0;
   localparam int CFG_POST   = 1;

   // Field layout of the CFG_POST word
   localparam int CFG_SHIFT_LSB = 0;
   localparam int CFG_SHIFT_W   = 8;
   localparam int CFG_POOL_LSB  = 8;
   localparam int CFG_POOL_W    = 8;
   localparam int CFG_RELU_BIT  = 16;
   localparam int CFG_USED_W    = CFG_RELU_BIT + 1;

   typedef struct packed {
      logic [CFG_SHIFT_W-1:0] shift;
      logic [CFG_POOL_W-1:0]  pool;
      logic                   relu;
   } post_cfg_t;

   localparam post_cfg_t POST_CFG_RESET = '{shift: 8'd0, pool: 8'd1, relu: 1'b0};

   function automatic post_cfg_t decode_post_cfg(input logic [CFG_USED_W-1:0] w);
      post_cfg_t c;
      c.shift = w[CFG_SHIFT_LSB +: CFG_SHIFT_W];
      c.pool  = w[CFG_POOL_LSB +: CFG_POOL_W];
      c.relu  = w[CFG_RELU_BIT];
      return c;
   endfunction

endpackage

// File: rtl/layers_post_if.sv
// rtl/layers_post_if.sv - config, accumulator and result signals of layers_post
interface layers_post_if #(
   parameter int CFG_DWIDTH = 32,
   parameter int CFG_AWIDTH = 5,
   parameter int DEPTH_NB   = 16,
   parameter int IMG_WIDTH  = 16,
   parameter int ACC_WIDTH  = 33
);
   logic [CFG_DWIDTH-1:0]          cfg_data;
   logic [CFG_AWIDTH-1:0]          cfg_addr;
   logic                           cfg_valid;
   logic [DEPTH_NB*ACC_WIDTH-1:0]  acc_bus;
   logic                           acc_last;
   logic                           acc_val;
   logic                           acc_rdy;
   logic [DEPTH_NB*IMG_WIDTH-1:0]  result_bus;
   logic                           result_last;
   logic                           result_val;
   logic                           result_rdy;

   modport master (
      output cfg_data, cfg_addr, cfg_valid, acc_bus, acc_last, acc_val, result_rdy,
      input  acc_rdy, result_bus, result_last, result_val
   );

   modport slave (
      input  cfg_data, cfg_addr, cfg_valid, acc_bus, acc_last, acc_val, result_rdy,
      output acc_rdy, result_bus, result_last, result_val
   );
endinterface

// File: rtl/layers_post_lane.sv
// rtl/layers_post_lane.sv - one lane: shift (rounding under LAYERS_POST_ROUND_EN), saturate/relu, pool max
module layers_post_lane #(
   parameter int IMG_WIDTH = 16,
   parameter int ACC_WIDTH = 33,
   parameter int SH_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic signed [ACC_WIDTH-1:0] acc,
   input  logic [SH_WIDTH-1:0]         sh,
   input  logic                        s1_relu,
   input  logic                        take,
   input  logic                        first,
   input  logic                        complete,
   output logic signed [IMG_WIDTH-1:0] res
);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-IMG_WIDTH+1){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-IMG_WIDTH+1){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH:0]   ext;
   logic signed [ACC_WIDTH:0]   biased;
   logic signed [ACC_WIDTH:0]   shifted;
   logic signed [ACC_WIDTH-1:0] s1_q;
   logic signed [IMG_WIDTH-1:0] sat_v;
   logic signed [IMG_WIDTH-1:0] s2_q;
   logic signed [IMG_WIDTH-1:0] acc_max;
   logic signed [IMG_WIDTH-1:0] cand;

   // S1 arithmetic: one guard bit so the rounding bias can never overflow
   always_comb begin
      ext    = {acc[ACC_WIDTH-1], acc};
      biased = ext;
`ifdef LAYERS_POST_ROUND_EN
      if (sh != '0) begin
         biased = ext + $signed((ACC_WIDTH+1)'(1) << (sh - 1'b1));
      end
`endif
      shifted = biased >>> sh;
   end

   // S2 arithmetic: clamp into the signed result range, then optional relu
   always_comb begin
      if (s1_q > SAT_MAX) begin
         sat_v = SAT_MAX[IMG_WIDTH-1:0];
      end else if (s1_q < SAT_MIN) begin
         sat_v = SAT_MIN[IMG_WIDTH-1:0];
      end else begin
         sat_v = s1_q[IMG_WIDTH-1:0];
      end
      if (s1_relu && sat_v[IMG_WIDTH-1]) begin
         sat_v = '0;
      end
   end

   // S3 arithmetic: the first sample of a window replaces the running max
   always_comb begin
      cand = (first || (s2_q > acc_max)) ? s2_q : acc_max;
   end

   // Stage registers, running max and the lane's slice of the result
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         acc_max <= '0;
         res     <= '0;
      end else begin
         if (en) begin
            s1_q <= shifted[ACC_WIDTH-1:0];
            s2_q <= sat_v;
         end
         if (take) begin
            acc_max <= cand;
            if (complete) begin
               res <= cand;
            end
         end
      end
   end

endmodule

// File: rtl/layers_post.sv
// rtl/layers_post.sv - post-accumulation shift/saturate/relu/max-pool stage; option LAYERS_POST_ROUND_EN
module layers_post
   import layers_post_pkg::*;
#(
   parameter int CFG_DWIDTH = 32,
   parameter int CFG_AWIDTH = 5,
   parameter int DEPTH_NB   = 16,
   parameter int IMG_WIDTH  = 16,
   parameter int KER_WIDTH  = 16,
   parameter int ACC_WIDTH  = IMG_WIDTH + KER_WIDTH + 1,
   parameter int POOL_WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   layers_post_if.slave bus
);

   localparam int SH_WIDTH = CFG_SHIFT_W;
   localparam int SH_MAX   = ACC_WIDTH - IMG_WIDTH;

   post_cfg_t               cfg_q;
   logic [CFG_DWIDTH-1:0]   cfg_word;
   logic                    cfg_wr;
   logic                    en;
   logic [SH_WIDTH-1:0]     sh;

   logic                    s1_val, s1_last, s1_relu;
   logic [CFG_POOL_W-1:0]   s1_pool;
   logic                    s2_val, s2_last;
   logic [CFG_POOL_W-1:0]   s2_pool;
   logic [POOL_WIDTH-1:0]   cnt;
   logic [POOL_WIDTH-1:0]   pool_eff;
   logic                    first, complete, take;

   logic                    result_val_q;
   logic                    result_last_q;
   logic [DEPTH_NB*IMG_WIDTH-1:0] res_flat;

   assign cfg_word = bus.cfg_data;
   assign cfg_wr   = bus.cfg_valid && (bus.cfg_addr == CFG_AWIDTH'(CFG_POST));

   // The whole pipeline freezes only while a result sits unaccepted
   assign en          = ~(result_val_q & ~bus.result_rdy);
   assign bus.acc_rdy = ~rst & en;

   assign bus.result_val  = result_val_q;
   assign bus.result_last = result_last_q;
   assign bus.result_bus  = res_flat;

   // Shift amount for the sample entering S1, capped so the result still fits
   always_comb begin
      sh = (cfg_q.shift > SH_WIDTH'(SH_MAX)) ? SH_WIDTH'(SH_MAX) : cfg_q.shift;
   end

   // Window control for the sample in S2, using the pool size it entered with
   always_comb begin
      pool_eff = (s2_pool == '0) ? POOL_WIDTH'(1) : POOL_WIDTH'(s2_pool);
      first    = (cnt == '0);
      complete = s2_last || (cnt == pool_eff - POOL_WIDTH'(1));
      take     = en && s2_val;
   end

   // Config, stage valids, pool counter and result flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q         <= POST_CFG_RESET;
         s1_val        <= 1'b0;
         s1_last       <= 1'b0;
         s1_relu       <= 1'b0;
         s1_pool       <= '0;
         s2_val        <= 1'b0;
         s2_last       <= 1'b0;
         s2_pool       <= '0;
         cnt           <= '0;
         result_val_q  <= 1'b0;
         result_last_q <= 1'b0;
      end else begin
         if (cfg_wr) begin
            cfg_q <= decode_post_cfg(cfg_word[CFG_USED_W-1:0]);
         end
         if (en) begin
            s1_val       <= bus.acc_val;
            s1_last      <= bus.acc_last;
            s1_relu      <= cfg_q.relu;
            s1_pool      <= cfg_q.pool;
            s2_val       <= s1_val;
            s2_last      <= s1_last;
            s2_pool      <= s1_pool;
            result_val_q <= s2_val && complete;
            if (s2_val) begin
               if (complete) begin
                  result_last_q <= s2_last;
                  cnt           <= '0;
               end else begin
                  cnt <= cnt + POOL_WIDTH'(1);
               end
            end
         end
         // A reconfiguration abandons any partially collected window
         if (cfg_wr) begin
            cnt <= '0;
         end
      end
   end

   for (genvar i = 0; i < DEPTH_NB; i++) begin : g_lane
      layers_post_lane #(
         .IMG_WIDTH (IMG_WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .SH_WIDTH  (SH_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .acc      (bus.acc_bus[i*ACC_WIDTH +: ACC_WIDTH]),
         .sh       (sh),
         .s1_relu  (s1_relu),
         .take     (take),
         .first    (first),
         .complete (complete),
         .res      (res_flat[i*IMG_WIDTH +: IMG_WIDTH])
      );
   end

endmodule
